// File: rtl/adc_lvds_pkg.sv
// Shared types and slot arithmetic for the LVDS ADC transmit emulator.
// Bit-order and wire-mode helpers mirror the receiver's channel/lane mapping.
package adc_lvds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_e;

    function automatic int slot_count(input int bits, input int wire_mode);
        return bits / wire_mode;
    endfunction

    // Sample bit carried by lane 'sub' of a channel during slot k.
    function automatic int lane_bit_idx(input int bits, input int wire_mode,
                                        input int msb_fst, input int k, input int sub);
        if (msb_fst != 0)
            return bits - 1 - wire_mode * k - sub;
        else
            return wire_mode * k + sub;
    endfunction

    function automatic int frm_high_len(input int slots);
        return (slots + 1) / 2;
    endfunction

endpackage

// File: rtl/adc_lvds_tx_lane.sv
// One channel of the transmitter: holds the current sample word and
// registers the AdcWireMode lane bits selected by the current slot.
module adc_lvds_tx_lane
    import adc_lvds_pkg::*;
#(
    parameter int AdcBits        = 14,
    parameter int AdcWireMode    = 1,
    parameter int AdcMsbOrLsbFst = 1,
    parameter int CntW           = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [AdcBits-1:0]     load_word,
    input  logic [CntW-1:0]        slot,
    input  logic                   active,
    output logic [AdcWireMode-1:0] lane_bits
);

    localparam int IdxW = $clog2(AdcBits);

    logic [AdcBits-1:0]     word_q, word_d;
    logic [AdcWireMode-1:0] lane_q, lane_d;
    logic [IdxW-1:0]        idx;

    always_comb begin
        word_d = load_en ? load_word : word_q;
        lane_d = '0;
        idx    = '0;
        if (active) begin
            for (int s = 0; s < AdcWireMode; s++) begin
                idx       = IdxW'(lane_bit_idx(AdcBits, AdcWireMode, AdcMsbOrLsbFst, int'(slot), s));
                lane_d[s] = word_q[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign lane_bits = lane_q;

endmodule

// File: rtl/adc_lvds_tx_emu.sv
// Serial-LVDS ADC link emulator: training frames, then handshaked sample frames.
// state | meaning
// IDLE  | outputs quiet, waiting for TxEna
// TRAIN | sending TrainFrames frames of AdcTrainWord for receiver alignment
// RUN   | sending accepted samples, repeating the last word on underrun
module adc_lvds_tx_emu
    import adc_lvds_pkg::*;
#(
    parameter int          AdcChnls       = 2,
    parameter int          AdcBits        = 14,
    parameter int          AdcWireMode    = 1,
    parameter int          AdcMsbOrLsbFst = 1,
    parameter logic [15:0] AdcTrainWord   = 16'h2A5A,
    parameter int          TrainFrames    = 4
) (
    input  logic                            SysClk,
    input  logic                            SysRst,
    input  logic                            TxEna,
    input  logic [AdcChnls*16-1:0]          SampData,
    input  logic                            SampValid,
    output logic                            SampReady,
    output logic [AdcChnls*AdcWireMode-1:0] DataBit,
    output logic                            FrmBit,
    output logic                            FrmStart,
    output logic                            Training,
    output logic                            Underrun
);

    localparam int Slots = slot_count(AdcBits, AdcWireMode);
    localparam int CntW  = $clog2(Slots);
    localparam int FrmW  = $clog2(TrainFrames + 1);
    localparam int FrmHi = frm_high_len(Slots);

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [FrmW-1:0] frm_cnt_q, frm_cnt_d;
    logic            frm_bit_q, frm_bit_d;
    logic            frm_start_q, frm_start_d;
    logic            training_q, training_d;
    logic            underrun_q, underrun_d;
    logic            samp_ready, load_en, load_train, last_slot, last_train, active;
    logic            samp_unused;

    always_comb begin
        last_slot  = (bit_cnt_q == CntW'(Slots - 1));
        last_train = (frm_cnt_q == FrmW'(TrainFrames - 1));
        active     = (state_q != ST_IDLE);
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        frm_cnt_d  = frm_cnt_q;
        load_en    = 1'b0;
        load_train = 1'b0;
        samp_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (TxEna) begin
                    state_d    = ST_TRAIN;
                    bit_cnt_d  = '0;
                    frm_cnt_d  = '0;
                    load_en    = 1'b1;
                    load_train = 1'b1;
                end
            end
            ST_TRAIN: begin
                bit_cnt_d = last_slot ? '0 : bit_cnt_q + CntW'(1);
                if (last_slot) begin
                    frm_cnt_d = frm_cnt_q + FrmW'(1);
                    if (!TxEna) begin
                        state_d = ST_IDLE;
                    end else if (last_train) begin
                        state_d    = ST_RUN;
                        samp_ready = 1'b1;
                    end else begin
                        load_en    = 1'b1;
                        load_train = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                bit_cnt_d = last_slot ? '0 : bit_cnt_q + CntW'(1);
                if (last_slot) begin
                    if (!TxEna)
                        state_d = ST_IDLE;
                    else
                        samp_ready = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A missed handshake leaves the word untouched, so the frame repeats.
        if (samp_ready && SampValid)
            load_en = 1'b1;

        frm_bit_d   = active && (bit_cnt_q < CntW'(FrmHi));
        frm_start_d = active && (bit_cnt_q == '0);
        training_d  = (state_q == ST_TRAIN);
        underrun_d  = samp_ready && !SampValid;
    end

    always_ff @(posedge SysClk) begin
        if (SysRst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            frm_cnt_q   <= '0;
            frm_bit_q   <= 1'b0;
            frm_start_q <= 1'b0;
            training_q  <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frm_cnt_q   <= frm_cnt_d;
            frm_bit_q   <= frm_bit_d;
            frm_start_q <= frm_start_d;
            training_q  <= training_d;
            underrun_q  <= underrun_d;
        end
    end

    for (genvar c = 0; c < AdcChnls; c++) begin : g_lane
        adc_lvds_tx_lane #(
            .AdcBits        (AdcBits),
            .AdcWireMode    (AdcWireMode),
            .AdcMsbOrLsbFst (AdcMsbOrLsbFst),
            .CntW           (CntW)
        ) u_lane (
            .clk       (SysClk),
            .rst       (SysRst),
            .load_en   (load_en),
            .load_word (load_train ? AdcTrainWord[AdcBits-1:0] : SampData[16*c +: AdcBits]),
            .slot      (bit_cnt_q),
            .active    (active),
            .lane_bits (DataBit[c*AdcWireMode +: AdcWireMode])
        );
    end

    assign samp_unused = ^SampData;
    assign SampReady   = samp_ready;
    assign FrmBit      = frm_bit_q;
    assign FrmStart    = frm_start_q;
    assign Training    = training_q;
    assign Underrun    = underrun_q;

endmodule

// File: tb/tb_adc_lvds_tx_emu.sv
// Directed bench: 2ch/14b/1-wire MSB-first instance plus a 1ch/2-wire LSB-first instance.
module tb_adc_lvds_tx_emu;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_ena, samp_valid;
    logic [31:0] samp_data;
    logic        samp_ready, frm_bit, frm_start, training, underrun;
    logic [1:0]  data_bit;

    logic        tx_ena2, samp_valid2;
    logic [15:0] samp_data2;
    logic        samp_ready2, frm_bit2, frm_start2, training2, underrun2;
    logic [1:0]  data_bit2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    adc_lvds_tx_emu u_dut (
        .SysClk    (clk),
        .SysRst    (rst),
        .TxEna     (tx_ena),
        .SampData  (samp_data),
        .SampValid (samp_valid),
        .SampReady (samp_ready),
        .DataBit   (data_bit),
        .FrmBit    (frm_bit),
        .FrmStart  (frm_start),
        .Training  (training),
        .Underrun  (underrun)
    );

    adc_lvds_tx_emu #(
        .AdcChnls       (1),
        .AdcBits        (14),
        .AdcWireMode    (2),
        .AdcMsbOrLsbFst (0)
    ) u_dut2 (
        .SysClk    (clk),
        .SysRst    (rst),
        .TxEna     (tx_ena2),
        .SampData  (samp_data2),
        .SampValid (samp_valid2),
        .SampReady (samp_ready2),
        .DataBit   (data_bit2),
        .FrmBit    (frm_bit2),
        .FrmStart  (frm_start2),
        .Training  (training2),
        .Underrun  (underrun2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic chk_idle1(input string tag);
        chk(tag, 32'({data_bit, frm_bit, frm_start, training, underrun, samp_ready}), 32'd0);
    endtask

    // One 14-slot frame of the main instance; lanes are expected MSB first.
    task automatic frame1(input logic [13:0] w0, input logic [13:0] w1, input logic trn,
                          input logic rdy, input logic give, input logic ena_next,
                          input logic [13:0] n0, input logic [13:0] n1);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("data", 32'(data_bit), 32'({w1[13-k], w0[13-k]}));
            chk("frmbit", 32'(frm_bit), 32'(k < 7));
            chk("frmstart", 32'(frm_start), 32'(k == 0));
            chk("training", 32'(training), 32'(trn));
            chk("underrun", 32'(underrun), 32'((k == 13) && rdy && !give));
            if (k == 4) tx_ena = ena_next;
            if (k == 12) begin
                #1;
                chk("ready", 32'(samp_ready), 32'(rdy));
                samp_valid = give;
                samp_data  = {2'b00, n1, 2'b00, n0};
            end else begin
                chk("ready_off", 32'(samp_ready), 32'd0);
            end
            if (k == 13) samp_valid = 1'b0;
        end
    endtask

    // One 7-slot frame of the 2-wire instance; e0/e1 list lane bits in slot order.
    task automatic frame2(input logic [6:0] e0, input logic [6:0] e1, input logic trn,
                          input logic rdy, input logic give, input logic ena_next,
                          input logic [15:0] nd);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("w2_data", 32'(data_bit2), 32'({e1[6-k], e0[6-k]}));
            chk("w2_frmbit", 32'(frm_bit2), 32'(k < 4));
            chk("w2_frmstart", 32'(frm_start2), 32'(k == 0));
            chk("w2_training", 32'(training2), 32'(trn));
            chk("w2_underrun", 32'(underrun2), 32'((k == 6) && rdy && !give));
            if (k == 2) tx_ena2 = ena_next;
            if (k == 5) begin
                #1;
                chk("w2_ready", 32'(samp_ready2), 32'(rdy));
                samp_valid2 = give;
                samp_data2  = nd;
            end
            if (k == 6) samp_valid2 = 1'b0;
        end
    endtask

    task automatic enable1();
        tx_ena = 1'b1;
        #1;
        chk("en_ready", 32'(samp_ready), 32'd0);
        @(negedge clk);
        chk("en_latency", 32'({frm_start, training, data_bit}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [13:0] tw, s0, s1;
        tw = 14'h2A5A;
        s0 = 14'h1234;
        s1 = 14'h0ABC;
        rst = 1'b1; tx_ena = 1'b0; samp_valid = 1'b0; samp_data = '0;
        tx_ena2 = 1'b0; samp_valid2 = 1'b0; samp_data2 = '0;
        repeat (3) @(negedge clk);
        chk_idle1("reset");
        chk("reset2", 32'({data_bit2, frm_bit2, frm_start2, training2, underrun2, samp_ready2}), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk_idle1("idle_off");
        end

        // Training, samples, underrun, boundary words, disable at BitCnt=5.
        enable1();
        for (int f = 0; f < 3; f++) frame1(tw, tw, 1'b1, 1'b0, 1'b0, 1'b1, 14'h0, 14'h0);
        frame1(tw, tw, 1'b1, 1'b1, 1'b1, 1'b1, s0, s1);
        frame1(s0, s1, 1'b0, 1'b1, 1'b1, 1'b1, s0, s1);
        frame1(s0, s1, 1'b0, 1'b1, 1'b0, 1'b1, 14'h0, 14'h0);
        frame1(s0, s1, 1'b0, 1'b1, 1'b1, 1'b1, 14'h3FFF, 14'h0001);
        frame1(14'h3FFF, 14'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 14'h0000, 14'h3FFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_idle1("idle_after_stop");
        end

        // Restart: training again; first RUN frame without a sample repeats the train word.
        enable1();
        for (int f = 0; f < 3; f++) frame1(tw, tw, 1'b1, 1'b0, 1'b0, 1'b1, 14'h0, 14'h0);
        frame1(tw, tw, 1'b1, 1'b1, 1'b0, 1'b1, 14'h0, 14'h0);
        frame1(tw, tw, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0, 14'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_idle1("idle_after_restart");
        end

        // Reset in the middle of a frame.
        enable1();
        repeat (5) @(negedge clk);
        chk("pre_abort_training", 32'(training), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle1("abort_reset");
        rst = 1'b0; tx_ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_idle1("after_abort");
        end

        // Two-wire, LSB-first instance with word 0x1234.
        tx_ena2 = 1'b1;
        @(negedge clk);
        chk("w2_latency", 32'({frm_start2, training2, data_bit2}), 32'd0);
        for (int f = 0; f < 3; f++) frame2(7'b0011000, 7'b1100111, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
        frame2(7'b0011000, 7'b1100111, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        frame2(7'b0110001, 7'b0010100, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (3) begin
            @(negedge clk);
            chk("w2_idle", 32'({data_bit2, frm_bit2, frm_start2, training2, underrun2, samp_ready2}), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
